scr1_reset_seq_ctrl: RTL and testbench
======================================

# scr1_reset_seq_ctrl

Reset sequencer controller for the SCR1 reset tree: drives an ordered set of domain resets (domain 0 most upstream, e.g. system, then core, then hart) out of one already-synchronized root reset. It holds all domains in reset for a fixed count after power-on and releases them one at a time at fixed intervals. It also serves partial re-reset requests, for example from the debug module or soft reset, through a valid/ready handshake. Its outputs feed the reset buffer and qualifier-adapter cells of each domain.

## Interface
Parameters:
- DOMAINS, 3, number of sequenced reset domains (≥2).
- HOLD_CYCLES, 4, clocks all targeted domains stay asserted before the first release (≥1).
- RELEASE_GAP, 2, clocks between consecutive domain releases (≥1).

Ports:
- clk  in  1  core clock.
- rst_n_mux  in  1  reset, asynchronous, active-low; already test-muxed and release-synchronized upstream.
- test_mode  in  1  DFT mode; bypasses sequenced outputs.
- test_rst_n  in  1  DFT reset, drives every rst_n_out bit when test_mode=1.
- sys_rst_req  in  1  synchronous level request for full reset of all domains; highest priority.
- req_valid  in  1  partial reset request valid.
- req_mask  in  DOMAINS  domains requested for reset.
- req_ready  out  1  request acceptance.
- rst_n_out  out  DOMAINS  domain resets, active-low.
- rst_status  out  DOMAINS  raw sequencer reset state, not affected by test_mode.
- seq_busy  out  1  sequence in progress.
- seq_done  out  1  one-cycle pulse when all domains are released.

## Operation
- FSM states: ASSERT, RELEASE, READY. Internal registers: down-counter cnt, domain index idx, start index.
- Async reset (rst_n_mux=0):
  - state=ASSERT, cnt=HOLD_CYCLES-1, idx=0, rst_status=0, seq_done=0.
  - Outputs: rst_n_out=0 (or test_rst_n in test mode), seq_busy=1, req_ready=0.
- ASSERT: targeted domains idx..DOMAINS-1 stay at 0.
  - cnt decrements each clock.
  - On the edge where cnt=0, the FSM releases domain idx (bit goes to 1), loads cnt=RELEASE_GAP-1 and goes to RELEASE.
  - If idx=DOMAINS-1, the FSM goes to READY instead.
- RELEASE: cnt decrements each clock.
  - On the edge where cnt=0, idx increments and the new domain idx is released.
  - When the last domain is released, the FSM goes to READY.
- READY is entered on the same edge as the last release. seq_done is high for exactly the following cycle. This applies after power-on, after sys_rst_req and after partial requests.
- seq_busy=1 in ASSERT and RELEASE, 0 in READY.
- req_ready = (state==READY) & ~sys_rst_req (combinational).
- Request acceptance is req_valid & req_ready.
  - Let L be the lowest set bit of req_mask.
  - On the accept edge, domains L..DOMAINS-1 go to 0, idx=L, cnt=HOLD_CYCLES-1 and the FSM goes to ASSERT.
  - Resetting a domain always resets all downstream domains. Domains below L keep their value.
- req_mask=0: accepted and no effect; state remains READY and no seq_done.
- sys_rst_req=1 in any state: on the next edge all domains go to 0, idx=0, cnt=HOLD_CYCLES-1 and the FSM goes to ASSERT.
  - While it stays high, cnt is reloaded every clock, so no release happens.
  - Countdown starts on the first edge after it drops.
- Simultaneous sys_rst_req and req_valid: sys_rst_req wins and the request is not accepted (req_ready=0).
- Partial request in flight: requests are blocked (req_ready=0) until READY. There is no queuing. The requester holds req_valid and req_mask stable until acceptance.
- rst_n_out = test_mode ? {DOMAINS{test_rst_n}} : rst_status. The FSM keeps running in test mode.

## Timing
- Edge numbering: edge 1 is the first rising clk after rst_n_mux deasserts.
- Domain k is released at edge HOLD_CYCLES + k·RELEASE_GAP (from power-on or from the first edge with sys_rst_req low).
- Partial request accepted at edge E with lowest bit L:
  - domains ≥L are low from edge E;
  - domain L+j is released at edge E + HOLD_CYCLES + j·RELEASE_GAP.
- sys_rst_req to rst_status low: 1 edge latency.
- seq_done is high in the cycle after the last release edge.
- All outputs except req_ready and rst_n_out (in test mode) are registered.
- Counter width is $clog2(max(HOLD_CYCLES, RELEASE_GAP)). Minimum width is 1.

## Test plan
- Power-on, DOMAINS=3, HOLD=4, GAP=2: rst_n_out bits 0, 1, 2 rise at edges 4, 6, 8. seq_done is high only in cycle 8→9. seq_busy falls at edge 8. req_ready=1 afterwards.
- Partial req_mask=3'b110 accepted at edge E: bits 2:1 are low from E, bit 1 rises at E+4, bit 2 rises at E+6, bit 0 stays 1, seq_done after E+6.
- sys_rst_req pulsed for 3 cycles mid-RELEASE (bit 0 released): all bits low next edge, stay low while the request is high, then the full power-on timing repeats from its deassertion.
- sys_rst_req and req_valid high in the same cycle in READY: req_ready=0, the request is not accepted, and a full reset results. req_mask=0 accepted: no output change and no seq_done.
- test_mode=1 with test_rst_n toggling: rst_n_out follows test_rst_n on all bits immediately. rst_status continues the normal sequence.
- rst_n_mux asserted mid-sequence: all outputs return to their reset values asynchronously, and the sequence restarts cleanly after release.

Source files
------------

// File: rtl/scr1_reset_seq_ctrl.sv
// SCR1 reset sequencer: holds, then releases reset domains in order
// from one synchronized root reset; serves partial re-reset requests.
module scr1_reset_seq_ctrl #(
  parameter int DOMAINS     = 3,
  parameter int HOLD_CYCLES = 4,
  parameter int RELEASE_GAP = 2
) (
  input  logic               clk,
  input  logic               rst_n_mux,
  input  logic               test_mode,
  input  logic               test_rst_n,
  input  logic               sys_rst_req,
  input  logic               req_valid,
  input  logic [DOMAINS-1:0] req_mask,
  output logic               req_ready,
  output logic [DOMAINS-1:0] rst_n_out,
  output logic [DOMAINS-1:0] rst_status,
  output logic               seq_busy,
  output logic               seq_done
);

  localparam int MAXC = (HOLD_CYCLES > RELEASE_GAP) ?
                        HOLD_CYCLES : RELEASE_GAP;
  localparam int CW = (MAXC > 1) ? $clog2(MAXC) : 1;
  localparam int IW = (DOMAINS > 1) ? $clog2(DOMAINS) : 1;

  localparam logic [CW-1:0] HOLD_LD = CW'(HOLD_CYCLES - 1);
  localparam logic [CW-1:0] GAP_LD  = CW'(RELEASE_GAP - 1);
  localparam logic [IW-1:0] LAST    = IW'(DOMAINS - 1);

  localparam logic [1:0] ST_ASSERT  = 2'd0;
  localparam logic [1:0] ST_RELEASE = 2'd1;
  localparam logic [1:0] ST_READY   = 2'd2;

  logic [1:0]         state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [IW-1:0]      idx_q, idx_d;
  logic [DOMAINS-1:0] status_q, status_d;
  logic               done_q, done_d;

  logic [IW-1:0]      idx_inc;
  logic [IW-1:0]      low_idx;
  logic               mask_nz;

  assign idx_inc = idx_q + IW'(1);
  assign mask_nz = |req_mask;

  // Lowest requested domain; everything downstream of it is re-reset.
  always_comb begin
    low_idx = '0;
    for (int i = DOMAINS - 1; i >= 0; i--) begin
      if (req_mask[i]) low_idx = IW'(i);
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    idx_d    = idx_q;
    status_d = status_q;
    done_d   = 1'b0;
    if (sys_rst_req) begin
      state_d  = ST_ASSERT;
      cnt_d    = HOLD_LD;
      idx_d    = '0;
      status_d = '0;
    end else begin
      unique case (1'b1)
        (state_q == ST_ASSERT): begin
          if (cnt_q == '0) begin
            status_d[idx_q] = 1'b1;
            cnt_d = GAP_LD;
            if (idx_q == LAST) begin
              state_d = ST_READY;
              done_d  = 1'b1;
            end else begin
              state_d = ST_RELEASE;
            end
          end else begin
            cnt_d = cnt_q - CW'(1);
          end
        end
        (state_q == ST_RELEASE): begin
          if (cnt_q == '0) begin
            idx_d = idx_inc;
            status_d[idx_inc] = 1'b1;
            cnt_d = GAP_LD;
            if (idx_inc == LAST) begin
              state_d = ST_READY;
              done_d  = 1'b1;
            end
          end else begin
            cnt_d = cnt_q - CW'(1);
          end
        end
        (state_q == ST_READY): begin
          if (req_valid && mask_nz) begin
            for (int i = 0; i < DOMAINS; i++) begin
              if (i >= int'(low_idx)) status_d[i] = 1'b0;
            end
            idx_d   = low_idx;
            cnt_d   = HOLD_LD;
            state_d = ST_ASSERT;
          end
        end
        default: begin
          state_d  = ST_ASSERT;
          cnt_d    = HOLD_LD;
          idx_d    = '0;
          status_d = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n_mux) begin
    if (!rst_n_mux) begin
      state_q  <= ST_ASSERT;
      cnt_q    <= HOLD_LD;
      idx_q    <= '0;
      status_q <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      status_q <= status_d;
      done_q   <= done_d;
    end
  end

  assign rst_status = status_q;
  assign seq_done   = done_q;
  assign seq_busy   = (state_q != ST_READY);
  assign req_ready  = (state_q == ST_READY) & ~sys_rst_req;
  assign rst_n_out  = test_mode ? {DOMAINS{test_rst_n}} : status_q;

endmodule

// File: tb/tb_scr1_reset_seq_ctrl.sv
// Bench for scr1_reset_seq_ctrl: directed and random steps checked
// against a release-schedule model of the domain resets.
module tb_scr1_reset_seq_ctrl;

  localparam int D = 3;
  localparam int H = 4;
  localparam int G = 2;

  logic         clk = 1'b0;
  logic         rst_n_mux;
  logic         test_mode;
  logic         test_rst_n;
  logic         sys_rst_req;
  logic         req_valid;
  logic [D-1:0] req_mask;
  logic         req_ready;
  logic [D-1:0] rst_n_out;
  logic [D-1:0] rst_status;
  logic         seq_busy;
  logic         seq_done;

  scr1_reset_seq_ctrl #(
    .DOMAINS(D), .HOLD_CYCLES(H), .RELEASE_GAP(G)
  ) dut (
    .clk        (clk),
    .rst_n_mux  (rst_n_mux),
    .test_mode  (test_mode),
    .test_rst_n (test_rst_n),
    .sys_rst_req(sys_rst_req),
    .req_valid  (req_valid),
    .req_mask   (req_mask),
    .req_ready  (req_ready),
    .rst_n_out  (rst_n_out),
    .rst_status (rst_status),
    .seq_busy   (seq_busy),
    .seq_done   (seq_done)
  );

  always #5 clk = ~clk;

  int passed = 0;
  int failed = 0;
  int total  = 0;

  // Model: each domain has a pending release edge number.
  int           n;
  int           sched [D];
  bit           pend  [D];
  logic [D-1:0] st;
  bit           done_e;

  function automatic bit m_busy();
    for (int k = 0; k < D; k++) if (pend[k]) return 1'b1;
    return 1'b0;
  endfunction

  task automatic model_reset();
    st     = '0;
    done_e = 1'b0;
    for (int k = 0; k < D; k++) begin
      pend[k]  = 1'b1;
      sched[k] = n + H + k * G;
    end
  endtask

  task automatic model_edge();
    bit rel;
    int lo;
    rel    = 1'b0;
    done_e = 1'b0;
    n++;
    if (sys_rst_req) begin
      st = '0;
      for (int k = 0; k < D; k++) begin
        pend[k]  = 1'b1;
        sched[k] = n + H + k * G;
      end
    end else if (req_valid && !m_busy()) begin
      if (req_mask != '0) begin
        lo = D;
        for (int k = D - 1; k >= 0; k--) if (req_mask[k]) lo = k;
        for (int k = lo; k < D; k++) begin
          st[k]    = 1'b0;
          pend[k]  = 1'b1;
          sched[k] = n + H + (k - lo) * G;
        end
      end
    end else begin
      for (int k = 0; k < D; k++) begin
        if (pend[k] && sched[k] == n) begin
          st[k]   = 1'b1;
          pend[k] = 1'b0;
          rel     = 1'b1;
        end
      end
      if (rel && !m_busy()) done_e = 1'b1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    logic [D-1:0] eo;
    eo = test_mode ? {D{test_rst_n}} : st;
    chk("rst_status", 32'(rst_status), 32'(st));
    chk("rst_n_out",  32'(rst_n_out),  32'(eo));
    chk("seq_busy",   32'(seq_busy),   32'(m_busy()));
    chk("seq_done",   32'(seq_done),   32'(done_e));
    chk("req_ready",  32'(req_ready),
        32'(!m_busy() && !sys_rst_req));
  endtask

  task automatic step();
    model_edge();
    @(posedge clk);
    #1 check_all();
  endtask

  initial begin
    rst_n_mux   = 1'b0;
    test_mode   = 1'b0;
    test_rst_n  = 1'b1;
    sys_rst_req = 1'b0;
    req_valid   = 1'b0;
    req_mask    = '0;
    n = 0;
    model_reset();
    #1 check_all();
    repeat (2) @(negedge clk);
    rst_n_mux = 1'b1;
    repeat (10) step();

    req_valid = 1'b1;
    req_mask  = 3'b110;
    step();
    req_valid = 1'b0;
    req_mask  = '0;
    repeat (8) step();

    sys_rst_req = 1'b1;
    step();
    sys_rst_req = 1'b0;
    repeat (5) step();
    sys_rst_req = 1'b1;
    repeat (3) step();
    sys_rst_req = 1'b0;
    repeat (10) step();

    sys_rst_req = 1'b1;
    req_valid   = 1'b1;
    req_mask    = 3'b100;
    #1 chk("ready_vs_sys", 32'(req_ready), 32'd0);
    step();
    sys_rst_req = 1'b0;
    req_valid   = 1'b0;
    repeat (9) step();

    req_valid = 1'b1;
    req_mask  = '0;
    step();
    req_valid = 1'b0;
    repeat (3) step();

    test_mode  = 1'b1;
    test_rst_n = 1'b0;
    #1 check_all();
    test_rst_n = 1'b1;
    #1 check_all();
    sys_rst_req = 1'b1;
    step();
    sys_rst_req = 1'b0;
    repeat (10) begin
      test_rst_n = ~test_rst_n;
      step();
    end
    test_mode  = 1'b0;
    test_rst_n = 1'b1;

    sys_rst_req = 1'b1;
    step();
    sys_rst_req = 1'b0;
    repeat (5) step();
    #2 rst_n_mux = 1'b0;
    model_reset();
    #1 check_all();
    @(negedge clk);
    rst_n_mux = 1'b1;
    repeat (10) step();

    repeat (120) begin
      sys_rst_req = ($urandom_range(0, 15) == 0);
      req_valid   = ($urandom_range(0, 2) == 0);
      req_mask    = D'($urandom);
      test_mode   = ($urandom_range(0, 3) == 0);
      test_rst_n  = 1'($urandom);
      step();
    end

    sys_rst_req = 1'b0;
    req_valid   = 1'b0;
    test_mode   = 1'b0;
    repeat (12) step();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
